// File: rtl/toggle_sched.sv
// Round-robin scheduler sharing one toggle flop among NREQ requesters; a grant commits (q flips) DELAY edges later unless aborted.
// Latency: grant edge E, commit edge E+DELAY, then one idle edge before the next grant. A waiting request simply stays pending.
module toggle_sched #(
    parameter int NREQ  = 4,
    parameter int DELAY = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            abort,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic            aborted,
    output logic            busy,
    output logic            q,
    output logic [15:0]     toggle_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(DELAY + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [PW-1:0]   r_sel, w_sel_nxt;
    logic [PW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [NREQ-1:0] r_done, w_done_nxt;
    logic            r_aborted, w_aborted_nxt;
    logic            r_q, w_q_nxt;
    logic [15:0]     r_count, w_count_nxt;

    logic [PW-1:0]   w_pick;
    logic            w_found;
    logic [PW-1:0]   w_sel_inc;

    // First requester at or after the round-robin pointer, wrapping modulo NREQ.
    always_comb begin
        logic [PW-1:0] v_k;
        w_pick  = '0;
        w_found = 1'b0;
        v_k     = '0;
        for (int i = 0; i < NREQ; i++) begin
            v_k = PW'((int'(r_rr_ptr) + i) % NREQ);
            if (!w_found && req[v_k]) begin
                w_found = 1'b1;
                w_pick  = v_k;
            end
        end
    end

    assign w_sel_inc = (r_sel == PW'(NREQ - 1)) ? '0 : r_sel + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_sel_nxt     = r_sel;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_gnt_nxt     = r_gnt;
        w_done_nxt    = '0;
        w_aborted_nxt = 1'b0;
        w_q_nxt       = r_q;
        w_count_nxt   = r_count;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_sel_nxt   = w_pick;
                    w_gnt_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
                    w_cnt_nxt   = CW'(DELAY);
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                // abort wins even on the commit edge
                if (abort) begin
                    w_aborted_nxt = 1'b1;
                    w_gnt_nxt     = '0;
                    w_rr_ptr_nxt  = w_sel_inc;
                    w_state_nxt   = IDLE;
                end else if (r_cnt == CW'(1)) begin
                    w_q_nxt      = ~r_q;
                    w_done_nxt   = r_gnt;
                    w_count_nxt  = r_count + 16'd1;
                    w_gnt_nxt    = '0;
                    w_rr_ptr_nxt = w_sel_inc;
                    w_state_nxt  = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_sel     <= '0;
            r_rr_ptr  <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_aborted <= 1'b0;
            r_q       <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sel     <= w_sel_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_gnt     <= w_gnt_nxt;
            r_done    <= w_done_nxt;
            r_aborted <= w_aborted_nxt;
            r_q       <= w_q_nxt;
            r_count   <= w_count_nxt;
        end
    end

    assign gnt          = r_gnt;
    assign done         = r_done;
    assign aborted      = r_aborted;
    assign busy         = (r_state == WAIT);
    assign q            = r_q;
    assign toggle_count = r_count;

endmodule

// File: tb/tb_toggle_sched.sv
// Bench for toggle_sched: directed scenarios plus randomized traffic against a transaction-level model
// that tracks the owner, the commit edge number and the round-robin pointer.
module tb_toggle_sched;

    localparam int NREQ  = 4;
    localparam int DELAY = 2;
    localparam logic [NREQ-1:0] ONE = 1;

    logic            clock;
    logic            reset;
    logic [NREQ-1:0] req;
    logic            abort;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic            aborted;
    logic            busy;
    logic            q;
    logic [15:0]     toggle_count;

    toggle_sched #(.NREQ(NREQ), .DELAY(DELAY)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .abort        (abort),
        .gnt          (gnt),
        .done         (done),
        .aborted      (aborted),
        .busy         (busy),
        .q            (q),
        .toggle_count (toggle_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model: a pending job knows its owner and the edge number on which it commits.
    int              m_edge;
    bit              m_pend;
    int              m_owner;
    int              m_commit;
    int              m_ptr;
    bit              m_q;
    int              m_cnt;
    logic [NREQ-1:0] m_done;
    bit              m_aborted;

    wire [26:0] obs = {q, busy, aborted, done, gnt, toggle_count};

    function automatic logic [26:0] exp_vec();
        logic [NREQ-1:0] g;
        g = m_pend ? (ONE << m_owner) : '0;
        return {m_q, m_pend, m_aborted, m_done, g, 16'(m_cnt)};
    endfunction

    task automatic model_reset();
        m_edge = 0; m_pend = 0; m_owner = 0; m_commit = 0; m_ptr = 0;
        m_q = 0; m_cnt = 0; m_done = '0; m_aborted = 0;
    endtask

    task automatic model_edge(input logic [NREQ-1:0] r, input logic a);
        bit found;
        int idx;
        found = 0;
        m_done = '0;
        m_aborted = 0;
        if (m_pend) begin
            if (a) begin
                m_aborted = 1;
                m_pend = 0;
                m_ptr = (m_owner + 1) % NREQ;
            end else if (m_edge == m_commit) begin
                m_q = !m_q;
                m_done = ONE << m_owner;
                m_cnt = (m_cnt + 1) % 65536;
                m_pend = 0;
                m_ptr = (m_owner + 1) % NREQ;
            end
        end else if (r != '0) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (!found && (((r >> idx) & ONE) != '0)) begin
                    found = 1;
                    m_owner = idx;
                end
            end
            m_pend = 1;
            m_commit = m_edge + DELAY;
        end
        m_edge++;
    endtask

    task automatic step(input logic [NREQ-1:0] r, input logic a);
        req = r;
        abort = a;
        @(posedge clock);
        model_edge(r, a);
        #1;
    endtask

    // Raise reset between edges; returns 1 time unit later so the caller can check the immediate effect.
    task automatic assert_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
    endtask

    task automatic release_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (obs !== 27'd0) begin
            n_err++;
            $display("FAIL reset_initial: got %h want %h", obs, 27'd0);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if (obs !== 27'd0) begin
            n_err++;
            $display("FAIL reset_held: got %h want %h", obs, 27'd0);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        step(4'b0010, 1'b0);
        n_cmp++;
        if ({gnt, busy} !== {4'b0010, 1'b1}) begin
            n_err++;
            $display("FAIL single_grant: got gnt=%b busy=%b want gnt=0010 busy=1", gnt, busy);
        end
        step(4'b0010, 1'b0);
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL single_wait: got %h want %h", obs, exp_vec());
        end
        step(4'b0010, 1'b0);
        n_cmp++;
        if ({q, done, gnt, toggle_count} !== {1'b1, 4'b0010, 4'b0000, 16'd1}) begin
            n_err++;
            $display("FAIL single_commit: got q=%b done=%b gnt=%b cnt=%0d want q=1 done=0010 gnt=0000 cnt=1",
                     q, done, gnt, toggle_count);
        end
        step(4'b0000, 1'b0);
        n_cmp++;
        if (obs !== exp_vec() || done !== 4'b0000) begin
            n_err++;
            $display("FAIL single_done_pulse: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_abort();
        step(4'b0001, 1'b0);
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL abort_grant: got %b want 0001", gnt);
        end
        step(4'b0001, 1'b1);
        n_cmp++;
        if ({aborted, q, done, gnt, busy, toggle_count} !== {1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 16'd1}) begin
            n_err++;
            $display("FAIL abort_cancel: got ab=%b q=%b done=%b gnt=%b busy=%b cnt=%0d want ab=1 q=1 done=0 gnt=0 busy=0 cnt=1",
                     aborted, q, done, gnt, busy, toggle_count);
        end
        step(4'b0011, 1'b0);
        n_cmp++;
        if (gnt !== 4'b0010 || aborted !== 1'b0) begin
            n_err++;
            $display("FAIL abort_next_grant: got gnt=%b ab=%b want gnt=0010 ab=0", gnt, aborted);
        end
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL abort_follow_commit: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_abort_at_commit();
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        n_cmp++;
        if ({aborted, done, q, toggle_count} !== {1'b1, 4'b0000, m_q, 16'(m_cnt)} || obs !== exp_vec()) begin
            n_err++;
            $display("FAIL abort_at_commit: got %h want %h", obs, exp_vec());
        end
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 1'b1);
            n_cmp++;
            if (obs !== exp_vec() || aborted !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL abort_idle_%0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] want_g [5];
        int gi;
        want_g[0] = 4'b0001; want_g[1] = 4'b0010; want_g[2] = 4'b0100;
        want_g[3] = 4'b1000; want_g[4] = 4'b0001;
        assert_reset();
        n_cmp++;
        if (obs !== 27'd0) begin
            n_err++;
            $display("FAIL rr_reset_immediate: got %h want %h", obs, 27'd0);
        end
        release_reset();
        gi = 0;
        for (int e = 0; e < 13; e++) begin
            step(4'b1111, 1'b0);
            if (e % 3 == 0) begin
                n_cmp++;
                if (gnt !== want_g[gi]) begin
                    n_err++;
                    $display("FAIL rr_order_%0d: got %b want %b", gi, gnt, want_g[gi]);
                end
                gi++;
            end else if (e % 3 == 2) begin
                n_cmp++;
                if (q !== ((e / 3) % 2 == 0) || done !== want_g[e / 3]) begin
                    n_err++;
                    $display("FAIL rr_commit_%0d: got q=%b done=%b want q=%b done=%b",
                             e / 3, q, done, ((e / 3) % 2 == 0), want_g[e / 3]);
                end
            end
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL rr_model_%0d: got %h want %h", e, obs, exp_vec());
            end
        end
        n_cmp++;
        if (toggle_count !== 16'd4 || q !== 1'b0) begin
            n_err++;
            $display("FAIL rr_count: got cnt=%0d q=%b want cnt=4 q=0", toggle_count, q);
        end
    endtask

    task automatic test_reset_mid_wait();
        step(4'b0100, 1'b0);
        assert_reset();
        n_cmp++;
        if ({q, gnt, busy, done, toggle_count} !== 26'd0) begin
            n_err++;
            $display("FAIL midwait_reset: got q=%b gnt=%b busy=%b done=%b cnt=%0d want all 0",
                     q, gnt, busy, done, toggle_count);
        end
        req = 4'b0000;
        release_reset();
        for (int i = 0; i < 4; i++) begin
            step(4'b0000, 1'b0);
            n_cmp++;
            if (done !== 4'b0000 || q !== 1'b0 || toggle_count !== 16'd0) begin
                n_err++;
                $display("FAIL midwait_after_%0d: got done=%b q=%b cnt=%0d want done=0 q=0 cnt=0",
                         i, done, q, toggle_count);
            end
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] r;
        logic a;
        r = '0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) r = NREQ'($urandom_range(0, 15));
            a = ($urandom_range(0, 99) < 15);
            step(r, a);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL random_%0d: got %h want %h (req=%b abort=%b)", i, obs, exp_vec(), r, a);
            end
            if ($urandom_range(0, 149) == 0) begin
                assert_reset();
                n_cmp++;
                if (obs !== 27'd0) begin
                    n_err++;
                    $display("FAIL random_reset_%0d: got %h want %h", i, obs, 27'd0);
                end
                release_reset();
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        abort = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_abort();
        test_abort_at_commit();
        test_round_robin();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
